// File: rtl/zint_ctrl.sv
// zint_ctrl: Z80 IM2 interrupt controller with NSRC prioritised sources.
// Source 0 has the highest priority. Each source can be masked. A source can
// also self-expire after PULSE_CLKS zpos ticks, or drop its starts while VDOS
// is active. A sticky overflow flag records lost requests. The IM2 vector of
// the acknowledged source is held between acknowledge cycles.
module zint_ctrl #(
    parameter int              NSRC       = 3,
    parameter logic [7:0]      VBASE      = 8'hFF,
    parameter int              PULSE_CLKS = 32,
    parameter logic [NSRC-1:0] AUTOEXP    = 3'b001,
    parameter logic [NSRC-1:0] VDOS_DROP  = 3'b011
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            zpos,
    input  logic [NSRC-1:0] int_start,
    input  logic [NSRC-1:0] intmask,
    input  logic            vdos,
    input  logic            intack,
    input  logic [NSRC-1:0] ovf_clr,
    output logic [7:0]      im2vect,
    output logic            int_n,
    output logic [NSRC-1:0] int_pend,
    output logic [NSRC-1:0] ovf
);

    localparam int CW = $clog2(PULSE_CLKS + 1);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PULSE_CLKS);

    logic            intack_reg;
    logic            ack_s;
    logic [NSRC-1:0] pend_reg;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] ovf_reg;
    logic [NSRC-1:0] ovf_next;
    logic [SW-1:0]   win;
    logic            any_pend;
    logic [SW-1:0]   sel_reg;
    logic [SW-1:0]   sel_next;
    logic            sel_vld_reg;
    logic            sel_vld_next;
    logic [7:0]      sel_ext;

    // One acknowledge strobe per rising edge of the CPU acknowledge level.
    assign ack_s    = intack & ~intack_reg;
    assign any_pend = |pend_reg;

    // Priority encoder: the lowest pending index wins. It uses only registered pend.
    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                win = SW'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic start_ok;
            logic start_drop;
            logic expire;
            logic ack_hit;

            assign start_ok   = int_start[gi] & ~(vdos & VDOS_DROP[gi]);
            assign start_drop = int_start[gi] & vdos & VDOS_DROP[gi];
            assign ack_hit    = ack_s & any_pend & (win == SW'(gi));

            if (AUTOEXP[gi]) begin : g_exp
                logic [CW-1:0] cnt_reg;
                logic [CW-1:0] cnt_next;

                // An accepted start restarts the count. The count advances on
                // zpos while the source is pending. It is frozen during VDOS and
                // saturates at the limit.
                assign cnt_next =
                    (intmask[gi] & start_ok) ? '0 :
                    (zpos & pend_reg[gi] & ~vdos & (cnt_reg < CNT_MAX)) ? cnt_reg + 1'b1 :
                    cnt_reg;
                assign expire = (cnt_reg == CNT_MAX);

                // Expire counter register.
                always_ff @(posedge clk or negedge res_n) begin
                    if (!res_n) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
            end else begin : g_noexp
                assign expire = 1'b0;
            end

            // The mask has the highest priority. A start beats expire and ack.
            assign pend_next[gi] =
                ~intmask[gi] ? 1'b0 :
                start_ok     ? 1'b1 :
                expire       ? 1'b0 :
                ack_hit      ? 1'b0 :
                pend_reg[gi];

            // The overflow flag is sticky. Setting it wins over a clear in the same clk.
            assign ovf_next[gi] =
                (intmask[gi] & int_start[gi] & (pend_reg[gi] | start_drop)) ? 1'b1 :
                ovf_clr[gi] ? 1'b0 :
                ovf_reg[gi];
        end
    endgenerate

    // Vector selection is captured on each ack strobe and held until the next one.
    always_comb begin
        sel_next     = sel_reg;
        sel_vld_next = sel_vld_reg;
        if (ack_s) begin
            if (any_pend) begin
                sel_next     = win;
                sel_vld_next = 1'b1;
            end else begin
                sel_vld_next = 1'b0;
            end
        end
    end

    // Core state registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pend_reg    <= '0;
            ovf_reg     <= '0;
            intack_reg  <= 1'b0;
            sel_reg     <= '0;
            sel_vld_reg <= 1'b0;
        end else begin
            pend_reg    <= pend_next;
            ovf_reg     <= ovf_next;
            intack_reg  <= intack;
            sel_reg     <= sel_next;
            sel_vld_reg <= sel_vld_next;
        end
    end

    // The vector steps down by 2 per source and wraps modulo 256.
    assign sel_ext  = {{(8 - SW){1'b0}}, sel_reg};
    assign im2vect  = sel_vld_reg ? (VBASE - (sel_ext << 1)) : VBASE;
    assign int_n    = ~any_pend | vdos;
    assign int_pend = pend_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_zint_ctrl.sv
// tb_zint_ctrl: directed scenarios plus randomized traffic, each checked
// against a behavioural model of the interrupt controller.
module tb_zint_ctrl;

    logic       clk = 1'b0;
    logic       res_n;
    logic       zpos;
    logic [2:0] int_start;
    logic [2:0] intmask;
    logic       vdos;
    logic       intack;
    logic [2:0] ovf_clr;
    logic [7:0] im2vect;
    logic       int_n;
    logic [2:0] int_pend;
    logic [2:0] ovf;

    int n_cmp = 0;
    int n_err = 0;

    localparam bit [2:0] AUTO = 3'b001;
    localparam bit [2:0] DROP = 3'b011;
    localparam int       P    = 32;

    zint_ctrl dut (
        .clk(clk), .res_n(res_n), .zpos(zpos), .int_start(int_start),
        .intmask(intmask), .vdos(vdos), .intack(intack), .ovf_clr(ovf_clr),
        .im2vect(im2vect), .int_n(int_n), .int_pend(int_pend), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model: flags per source, tick counts and the last acked source.
    bit m_pend[3];
    int m_cnt[3];
    bit m_ovf[3];
    bit m_ack_prev;
    int m_sel;   // -1: no valid selection

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
        end
        m_ack_prev = 0;
        m_sel = -1;
    endtask

    task automatic model_step();
        bit ack;
        int w;
        bit np[3];
        int nc[3];
        bit no[3];
        ack = intack && !m_ack_prev;
        w = -1;
        for (int i = 0; i < 3; i++) if (m_pend[i] && w < 0) w = i;
        for (int i = 0; i < 3; i++) begin
            bit dropped, acc;
            dropped = int_start[i] && vdos && DROP[i];
            acc = int_start[i] && !dropped;
            np[i] = m_pend[i]; nc[i] = m_cnt[i]; no[i] = m_ovf[i];
            if (!intmask[i]) np[i] = 0;
            else if (acc) np[i] = 1;
            else if (AUTO[i] && m_cnt[i] == P) np[i] = 0;
            else if (ack && w == i) np[i] = 0;
            if (intmask[i] && acc) nc[i] = 0;
            else if (zpos && m_pend[i] && !vdos && m_cnt[i] < P) nc[i] = m_cnt[i] + 1;
            if (intmask[i] && int_start[i] && (m_pend[i] || dropped)) no[i] = 1;
            else if (ovf_clr[i]) no[i] = 0;
        end
        if (ack) m_sel = w;
        m_ack_prev = intack;
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = np[i]; m_cnt[i] = nc[i]; m_ovf[i] = no[i];
        end
    endtask

    function automatic logic [2:0] m_pend_vec();
        return {m_pend[2], m_pend[1], m_pend[0]};
    endfunction

    function automatic logic [2:0] m_ovf_vec();
        return {m_ovf[2], m_ovf[1], m_ovf[0]};
    endfunction

    function automatic logic [7:0] m_vect();
        int v;
        if (m_sel < 0) return 8'hFF;
        v = (255 - 2 * m_sel) % 256;
        return 8'(v);
    endfunction

    function automatic logic m_int_n();
        return !(m_pend[0] || m_pend[1] || m_pend[2]) || vdos;
    endfunction

    // Advance one clock. The model follows the same edge. Pulse inputs drop afterwards.
    task automatic tick();
        @(posedge clk);
        if (res_n) model_step(); else model_reset();
        #1;
        int_start = '0;
        ovf_clr   = '0;
        zpos      = 1'b0;
    endtask

    task automatic test_reset();
        res_n = 1'b0; zpos = 0; int_start = '0; intmask = 3'b111;
        vdos = 0; intack = 0; ovf_clr = '0;
        model_reset();
        #1;
        if (int_n !== 1'b1) begin $display("FAIL reset_int_n: got %b expected 1", int_n); n_err++; end
        n_cmp++;
        if (im2vect !== 8'hFF) begin $display("FAIL reset_vect: got %h expected ff", im2vect); n_err++; end
        n_cmp++;
        if (int_pend !== 3'b000) begin $display("FAIL reset_pend: got %b expected 000", int_pend); n_err++; end
        n_cmp++;
        if (ovf !== 3'b000) begin $display("FAIL reset_ovf: got %b expected 000", ovf); n_err++; end
        n_cmp++;
        tick(); tick();
        @(negedge clk); res_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single();
        int_start = 3'b010; tick();
        if (int_pend !== 3'b010) begin $display("FAIL single_pend: got %b expected 010", int_pend); n_err++; end
        n_cmp++;
        if (int_n !== 1'b0) begin $display("FAIL single_int_n: got %b expected 0", int_n); n_err++; end
        n_cmp++;
        intack = 1;
        repeat (4) tick();
        if (im2vect !== 8'hFD) begin $display("FAIL single_vect: got %h expected fd", im2vect); n_err++; end
        n_cmp++;
        if (int_pend !== 3'b000 || int_n !== 1'b1) begin
            $display("FAIL single_clear: got pend=%b int_n=%b expected pend=000 int_n=1", int_pend, int_n); n_err++;
        end
        n_cmp++;
        intack = 0; tick();
        $display("test_single done");
    endtask

    task automatic test_two_sources();
        int_start = 3'b101; tick();
        intack = 1; tick();
        if (im2vect !== 8'hFF || int_pend !== 3'b100) begin
            $display("FAIL two_first: got vect=%h pend=%b expected ff/100", im2vect, int_pend); n_err++;
        end
        n_cmp++;
        intack = 0; tick();
        intack = 1; tick();
        if (im2vect !== 8'hFB || int_pend !== 3'b000) begin
            $display("FAIL two_second: got vect=%h pend=%b expected fb/000", im2vect, int_pend); n_err++;
        end
        n_cmp++;
        intack = 0; tick();
        $display("test_two_sources done");
    endtask

    task automatic test_autoexpire();
        // Plain run: 32 ticks expire the source.
        int_start = 3'b001; tick();
        for (int k = 0; k < 31; k++) begin
            zpos = 1; tick();
            if (int_pend !== m_pend_vec()) begin
                $display("FAIL exp_run: tick %0d got %b expected %b", k, int_pend, m_pend_vec()); n_err++;
            end
            n_cmp++;
        end
        tick(); tick();
        if (int_pend[0] !== 1'b1) begin $display("FAIL exp_31: got %b expected 1", int_pend[0]); n_err++; end
        n_cmp++;
        zpos = 1; tick(); tick();
        if (int_pend[0] !== 1'b0) begin $display("FAIL exp_32: got %b expected 0", int_pend[0]); n_err++; end
        n_cmp++;
        // With a 10-tick VDOS freeze the source needs 42 ticks.
        int_start = 3'b001; tick();
        repeat (16) begin zpos = 1; tick(); end
        vdos = 1;
        repeat (10) begin zpos = 1; tick(); end
        if (int_n !== 1'b1 || int_pend[0] !== 1'b1) begin
            $display("FAIL exp_vdos_hold: got int_n=%b pend0=%b expected 1/1", int_n, int_pend[0]); n_err++;
        end
        n_cmp++;
        vdos = 0;
        repeat (15) begin zpos = 1; tick(); end
        tick();
        if (int_pend[0] !== 1'b1) begin $display("FAIL exp_41: got %b expected 1", int_pend[0]); n_err++; end
        n_cmp++;
        zpos = 1; tick(); tick();
        if (int_pend[0] !== 1'b0) begin $display("FAIL exp_42: got %b expected 0", int_pend[0]); n_err++; end
        n_cmp++;
        $display("test_autoexpire done");
    endtask

    task automatic test_vdos();
        vdos = 1; int_start = 3'b101; tick();
        if (int_n !== 1'b1 || int_pend !== 3'b100 || ovf !== 3'b001) begin
            $display("FAIL vdos_drop: got int_n=%b pend=%b ovf=%b expected 1/100/001", int_n, int_pend, ovf); n_err++;
        end
        n_cmp++;
        vdos = 0; #1;
        if (int_n !== 1'b0) begin $display("FAIL vdos_release: got %b expected 0", int_n); n_err++; end
        n_cmp++;
        intack = 1; tick();
        if (im2vect !== 8'hFB) begin $display("FAIL vdos_vect: got %h expected fb", im2vect); n_err++; end
        n_cmp++;
        intack = 0; ovf_clr = 3'b001; tick();
        $display("test_vdos done");
    endtask

    task automatic test_overflow();
        int_start = 3'b010; tick();
        int_start = 3'b010; tick();
        if (ovf !== 3'b010) begin $display("FAIL ovf_set: got %b expected 010", ovf); n_err++; end
        n_cmp++;
        int_start = 3'b010; ovf_clr = 3'b010; tick();
        if (ovf !== 3'b010) begin $display("FAIL ovf_set_wins: got %b expected 010", ovf); n_err++; end
        n_cmp++;
        ovf_clr = 3'b010; tick();
        if (ovf !== 3'b000) begin $display("FAIL ovf_clear: got %b expected 000", ovf); n_err++; end
        n_cmp++;
        intmask = 3'b101; tick();
        if (int_pend[1] !== 1'b0 || ovf !== 3'b000) begin
            $display("FAIL mask_clear: got pend1=%b ovf=%b expected 0/000", int_pend[1], ovf); n_err++;
        end
        n_cmp++;
        intmask = 3'b111; tick();
        $display("test_overflow done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int_start = ($urandom % 4 == 0) ? 3'($urandom) : 3'b000;
            intmask   = ($urandom % 16 == 0) ? 3'($urandom) : 3'b111;
            if ($urandom % 20 == 0) vdos = ~vdos;
            if ($urandom % 3 == 0) intack = ~intack;
            zpos      = 1'($urandom % 2);
            ovf_clr   = ($urandom % 8 == 0) ? 3'($urandom) : 3'b000;
            tick();
            if (int_pend !== m_pend_vec() || ovf !== m_ovf_vec() ||
                im2vect !== m_vect() || int_n !== m_int_n()) begin
                $display("FAIL random cyc %0d: got pend=%b ovf=%b vect=%h int_n=%b expected %b/%b/%h/%b",
                         c, int_pend, ovf, im2vect, int_n, m_pend_vec(), m_ovf_vec(), m_vect(), m_int_n());
                n_err++;
            end
            n_cmp++;
        end
        vdos = 0; intack = 0; intmask = 3'b111; tick();
        $display("test_random done");
    endtask

    task automatic test_idle_ack_and_async_reset();
        intmask = 3'b000; tick();
        intmask = 3'b111; tick();
        intack = 1; tick();
        if (im2vect !== 8'hFF) begin $display("FAIL idle_vect: got %h expected ff", im2vect); n_err++; end
        n_cmp++;
        intack = 0; tick();
        int_start = 3'b010; tick();
        if (int_n !== 1'b0) begin $display("FAIL pre_reset_int_n: got %b expected 0", int_n); n_err++; end
        n_cmp++;
        @(negedge clk); #2;
        res_n = 1'b0; #1;
        model_reset();
        if (int_n !== 1'b1 || int_pend !== 3'b000) begin
            $display("FAIL async_reset: got int_n=%b pend=%b expected 1/000", int_n, int_pend); n_err++;
        end
        n_cmp++;
        tick();
        @(negedge clk); res_n = 1'b1;
        tick();
        $display("test_idle_ack_and_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_sources();
        test_autoexpire();
        test_vdos();
        test_overflow();
        test_random();
        test_idle_ack_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
